// File: rtl/serial_adder.sv
// Bit-serial A+B+cin through one full-adder cell; result WIDTH cycles after the accepting edge.
// No backpressure: start is taken only when not computing; sum/cout hold until the next completion.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_sh_next;

    assign fa_s        = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_c        = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    // Written as shifts so WIDTH=1 needs no special slice.
    assign sum_sh_next = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            // The strobe cycle also takes a new request, giving one op per WIDTH+1 cycles.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_sh_next;
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = sum_sh_next;
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=4 and WIDTH=1 instances, scoreboard of expected {cout,sum}.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp4_q[$];
    logic [1:0] exp1_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) u_add4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder #(.WIDTH(1)) u_add1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the selected instance; cyc=-1 when the budget expires.
    task automatic wait_done(input bit sel1, output int cyc);
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((sel1 ? done1 : done4) === 1'b1) begin
                cyc = i + 1;
                return;
            end
        end
    endtask

    // Drives one WIDTH=4 request through the accepting edge and records the expected result.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        exp4_q.push_back({1'b0, a} + {1'b0, b} + {4'd0, c});
        tick();
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick(); tick();
        checks++;
        if ({busy4, done4, cout4, sum4} !== 7'd0) begin
            failures++;
            $display("FAIL reset4 got=%b exp=%b", {busy4, done4, cout4, sum4}, 7'd0);
        end
        checks++;
        if ({busy1, done1, cout1, sum1} !== 4'd0) begin
            failures++;
            $display("FAIL reset1 got=%b exp=%b", {busy1, done1, cout1, sum1}, 4'd0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [4:0] e;
        issue4(4'd5, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy4, done4} !== 2'b10) begin
                failures++;
                $display("FAIL basic_busy cyc=%0d got=%b exp=10", i, {busy4, done4});
            end
            tick();
        end
        checks++;
        if ({busy4, done4} !== 2'b01) begin
            failures++;
            $display("FAIL basic_done got=%b exp=01", {busy4, done4});
        end
        e = 5'h1f;
        if (exp4_q.size() > 0) e = exp4_q.pop_front();
        checks++;
        if ({cout4, sum4} !== e || e !== 5'd8) begin
            failures++;
            $display("FAIL basic_sum got=%0d exp=%0d", {cout4, sum4}, e);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({done4, cout4, sum4} !== {1'b0, e}) begin
                failures++;
                $display("FAIL basic_hold cyc=%0d got=%b exp=%b", i, {done4, cout4, sum4}, {1'b0, e});
            end
        end
    endtask

    task automatic test_carry();
        logic [3:0] ta[4] = '{4'd15, 4'd9, 4'd0, 4'd15};
        logic [3:0] tb[4] = '{4'd1, 4'd7, 4'd0, 4'd15};
        logic       tc[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] e;
        int         cyc;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) issue4(ta[k], tb[k], tc[k]);
            else issue4(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
            wait_done(1'b0, cyc);
            checks++;
            if (cyc != 4) begin
                failures++;
                $display("FAIL carry_latency op=%0d got=%0d exp=4", k, cyc);
            end
            e = exp4_q.pop_front();
            checks++;
            if ({cout4, sum4} !== e) begin
                failures++;
                $display("FAIL carry_sum op=%0d got=%0d exp=%0d", k, {cout4, sum4}, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        int         cyc;
        a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0; start4 = 1'b1;
        exp4_q.push_back(5'd4);
        tick();
        a4 = 4'd7; b4 = 4'd7;
        exp4_q.push_back(5'd14);
        wait_done(1'b0, cyc);
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("FAIL b2b_latency1 got=%0d exp=4", cyc);
        end
        e = exp4_q.pop_front();
        checks++;
        if ({cout4, sum4} !== e) begin
            failures++;
            $display("FAIL b2b_sum1 got=%0d exp=%0d", {cout4, sum4}, e);
        end
        tick();
        start4 = 1'b0;
        checks++;
        if ({busy4, done4} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_accept got=%b exp=10", {busy4, done4});
        end
        wait_done(1'b0, cyc);
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("FAIL b2b_latency2 got=%0d exp=4", cyc);
        end
        e = exp4_q.pop_front();
        checks++;
        if ({cout4, sum4} !== e) begin
            failures++;
            $display("FAIL b2b_sum2 got=%0d exp=%0d", {cout4, sum4}, e);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        bit seen = 1'b0;
        a4 = 4'd6; b4 = 4'd7; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy4, done4, cout4, sum4} !== 7'd0) begin
            failures++;
            $display("FAIL abort_state got=%b exp=%b", {busy4, done4, cout4, sum4}, 7'd0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done4 === 1'b1 || busy4 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=0", seen);
        end
    endtask

    task automatic test_rst_priority();
        logic [4:0] e;
        int         cyc;
        rst = 1'b1; start4 = 1'b1; a4 = 4'd3; b4 = 4'd3; cin4 = 1'b0;
        tick();
        rst = 1'b0; start4 = 1'b0;
        checks++;
        if ({busy4, done4} !== 2'b00) begin
            failures++;
            $display("FAIL prio_idle got=%b exp=00", {busy4, done4});
        end
        tick();
        checks++;
        if ({busy4, done4} !== 2'b00) begin
            failures++;
            $display("FAIL prio_stay got=%b exp=00", {busy4, done4});
        end
        issue4(4'd0, 4'd0, 1'b0);
        wait_done(1'b0, cyc);
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("FAIL prio_latency got=%0d exp=4", cyc);
        end
        e = exp4_q.pop_front();
        checks++;
        if ({cout4, sum4} !== e) begin
            failures++;
            $display("FAIL prio_sum got=%0d exp=%0d", {cout4, sum4}, e);
        end
        tick();
    endtask

    task automatic test_width1();
        logic [1:0] e;
        int         cyc;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        exp1_q.push_back(2'(a1) + 2'(b1) + 2'(cin1));
        tick();
        start1 = 1'b0;
        checks++;
        if ({busy1, done1} !== 2'b10) begin
            failures++;
            $display("FAIL w1_busy got=%b exp=10", {busy1, done1});
        end
        wait_done(1'b1, cyc);
        checks++;
        if (cyc != 1) begin
            failures++;
            $display("FAIL w1_latency got=%0d exp=1", cyc);
        end
        e = exp1_q.pop_front();
        checks++;
        if ({cout1, sum1} !== e || e !== 2'b11) begin
            failures++;
            $display("FAIL w1_sum got=%b exp=%b", {cout1, sum1}, e);
        end
        tick();
        checks++;
        if ({busy1, done1, cout1, sum1} !== {2'b00, e}) begin
            failures++;
            $display("FAIL w1_hold got=%b exp=%b", {busy1, done1, cout1, sum1}, {2'b00, e});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_abort();
        test_rst_priority();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
